// File: rtl/wall_segment_sequencer.sv
// ============================================================================
// wall_segment_sequencer
// ----------------------------------------------------------------------------
// Purpose
//   Builds 64-row wall segments into a local 64x6 buffer for the wall ring
//   buffer. The ring buffer pulls a segment in one burst (hold/data_addr),
//   after which the buffer is rebuilt.
//
//   A segment is composed of patterns chosen by a 16-bit LFSR. Each pattern
//   is rotated left by 0..5 bits. Runs of empty gap rows separate the
//   patterns, and the gap length depends on difficulty.
//
// Parameters
//   SEED       LFSR reset value. A value of 0 is replaced by 16'hACE1.
//   START_GAP  Number of empty rows at the head of the first segment after
//              reset (0..63).
//
// Ports
//   clk         in   1  system clock
//   reset       in   1  synchronous, active-high reset
//   difficulty  in   2  gap rows between patterns = 6 - difficulty
//   hold        in   1  wall buffer is writing data this cycle
//   data_addr   in   6  row index being written by the wall buffer
//   data        out  6  row bitmask for data_addr (combinational, 0 if !ready)
//   ready       out  1  buffer holds a complete segment
//   underrun    out  1  sticky: hold seen while not ready
//
// Configuration macro
//   WALL_SEQ_MIRROR_EN  When defined, lfsr[5] of the freshly advanced LFSR
//                       mirrors the pattern (bit i -> bit 5-i) before
//                       rotation, and the rotation is taken from lfsr[8:6].
//                       When undefined, there is no mirroring and the
//                       rotation is taken from lfsr[4:2].
// ============================================================================
module wall_segment_sequencer #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          START_GAP = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] difficulty,
    input  logic       hold,
    input  logic [5:0] data_addr,
    output logic [5:0] data,
    output logic       ready,
    output logic       underrun
);

    localparam logic [15:0] SEED_EFF    = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [5:0]  START_GAP_L = 6'(START_GAP);
    localparam logic [5:0]  LAST_ROW    = 6'd63;

    typedef enum logic [1:0] {
        ST_GAP  = 2'd0,
        ST_PICK = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_reg,    state_next;
    logic [5:0]  gap_cnt_reg,  gap_cnt_next;
    logic [5:0]  wr_row_reg,   wr_row_next;
    logic [1:0]  row_idx_reg,  row_idx_next;
    logic [1:0]  pat_reg,      pat_next;
    logic [2:0]  rot_reg,      rot_next;
    logic [15:0] lfsr_reg,     lfsr_next;
    logic        underrun_reg, underrun_next;
`ifdef WALL_SEQ_MIRROR_EN
    logic        mirror_reg,   mirror_next;
`endif

    // Segment buffer. The consumer writes the row into its own storage in
    // the same cycle it presents data_addr. For that reason this buffer is
    // read asynchronously (distributed RAM) rather than through a
    // registered block-RAM port.
    logic [5:0] seg_mem [64];

    logic       wr_en;
    logic [5:0] wr_data;

    // ------------------------------------------------------------------
    // LFSR step
    // The LFSR shifts left and feeds back into bit 0. Taps 16,14,13,11 are
    // numbered from the output end (tap k is bit 16-k), so the feedback
    // uses bits 0,2,3,5. From ACE1, the first step therefore gives 59C2.
    // ------------------------------------------------------------------
    logic        lfsr_fb;
    logic [15:0] lfsr_adv;

    assign lfsr_fb  = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];
    assign lfsr_adv = {lfsr_reg[14:0], lfsr_fb};

    // Three LFSR bits select the rotation. The values 6 and 7 fold back
    // onto 0 and 1.
    logic [2:0] rot_raw;
    logic [2:0] rot_mod6;

`ifdef WALL_SEQ_MIRROR_EN
    assign rot_raw = lfsr_adv[8:6];
`else
    assign rot_raw = lfsr_adv[4:2];
`endif
    assign rot_mod6 = (rot_raw >= 3'd6) ? (rot_raw - 3'd6) : rot_raw;

    // ------------------------------------------------------------------
    // Pattern ROM (rows listed in emit order)
    // ------------------------------------------------------------------
    logic [5:0] rom_row;
    logic [1:0] pat_last_idx;

    always_comb begin
        rom_row      = 6'b000000;
        pat_last_idx = 2'd0;
        case (pat_reg)
            2'd0: begin
                rom_row      = 6'b111110;
                pat_last_idx = 2'd0;
            end
            2'd1: begin
                rom_row      = (row_idx_reg == 2'd0) ? 6'b111100 : 6'b000000;
                pat_last_idx = 2'd1;
            end
            2'd2: begin
                case (row_idx_reg)
                    2'd0:    rom_row = 6'b100100;
                    2'd1:    rom_row = 6'b010010;
                    default: rom_row = 6'b001001;
                endcase
                pat_last_idx = 2'd2;
            end
            default: begin
                rom_row      = 6'b101010;
                pat_last_idx = 2'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Optional mirror, followed by all six rotations of the selected row.
    // ------------------------------------------------------------------
    logic [5:0] row_rev;
    logic [5:0] row_src;
    logic [11:0] row_dbl;
    logic [5:0] rot_opts [6];
    logic [5:0] emit_row;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_rev
            assign row_rev[gi] = rom_row[5-gi];
        end
    endgenerate

`ifdef WALL_SEQ_MIRROR_EN
    assign row_src = mirror_reg ? row_rev : rom_row;
`else
    // Without the mirror option the reversed row is never selected.
    assign row_src = rom_row;
    logic unused_rev;
    assign unused_rev = ^row_rev;
`endif

    // rotl6(r,k) is the k-bit-shifted window of {r,r}.
    assign row_dbl = {row_src, row_src};

    generate
        for (gi = 0; gi < 6; gi++) begin : g_rot
            assign rot_opts[gi] = row_dbl[11-gi -: 6];
        end
    endgenerate

    always_comb begin
        emit_row = rot_opts[0];
        case (rot_reg)
            3'd1:    emit_row = rot_opts[1];
            3'd2:    emit_row = rot_opts[2];
            3'd3:    emit_row = rot_opts[3];
            3'd4:    emit_row = rot_opts[4];
            3'd5:    emit_row = rot_opts[5];
            default: emit_row = rot_opts[0];
        endcase
    end

    function automatic logic [5:0] gap_rows(input logic [1:0] d);
        return 6'd6 - {4'b0000, d};
    endfunction

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_GAP;
            gap_cnt_reg  <= START_GAP_L;
            wr_row_reg   <= 6'd0;
            row_idx_reg  <= 2'd0;
            pat_reg      <= 2'd0;
            rot_reg      <= 3'd0;
            lfsr_reg     <= SEED_EFF;
            underrun_reg <= 1'b0;
`ifdef WALL_SEQ_MIRROR_EN
            mirror_reg   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            gap_cnt_reg  <= gap_cnt_next;
            wr_row_reg   <= wr_row_next;
            row_idx_reg  <= row_idx_next;
            pat_reg      <= pat_next;
            rot_reg      <= rot_next;
            lfsr_reg     <= lfsr_next;
            underrun_reg <= underrun_next;
`ifdef WALL_SEQ_MIRROR_EN
            mirror_reg   <= mirror_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        gap_cnt_next  = gap_cnt_reg;
        wr_row_next   = wr_row_reg;
        row_idx_next  = row_idx_reg;
        pat_next      = pat_reg;
        rot_next      = rot_reg;
        lfsr_next     = lfsr_reg;
`ifdef WALL_SEQ_MIRROR_EN
        mirror_next   = mirror_reg;
`endif
        // Underrun is sticky; only reset clears it.
        underrun_next = underrun_reg | (hold & (state_reg != ST_DONE));

        case (state_reg)
            ST_GAP: begin
                if (gap_cnt_reg == 6'd0) begin
                    // A gap entered with a zero count writes nothing.
                    state_next = ST_PICK;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 6'd1;
                    wr_row_next  = wr_row_reg + 6'd1;
                    if (wr_row_reg == LAST_ROW) begin
                        state_next = ST_DONE;
                    end else if (gap_cnt_reg == 6'd1) begin
                        state_next = ST_PICK;
                    end
                end
            end

            ST_PICK: begin
                lfsr_next    = lfsr_adv;
                pat_next     = lfsr_adv[1:0];
                rot_next     = rot_mod6;
`ifdef WALL_SEQ_MIRROR_EN
                mirror_next  = lfsr_adv[5];
`endif
                row_idx_next = 2'd0;
                // EMIT does not use gap_cnt, so the gap length that
                // follows this pattern is latched here. That is the point
                // at which difficulty is sampled.
                gap_cnt_next = gap_rows(difficulty);
                state_next   = ST_EMIT;
            end

            ST_EMIT: begin
                wr_row_next  = wr_row_reg + 6'd1;
                row_idx_next = row_idx_reg + 2'd1;
                // Filling the last row ends the segment even mid-pattern.
                // The remainder of that pattern is dropped.
                if (wr_row_reg == LAST_ROW) begin
                    state_next = ST_DONE;
                end else if (row_idx_reg == pat_last_idx) begin
                    state_next = ST_GAP;
                end
            end

            ST_DONE: begin
                if (hold && (data_addr == LAST_ROW)) begin
                    state_next   = ST_GAP;
                    wr_row_next  = 6'd0;
                    gap_cnt_next = gap_rows(difficulty);
                end
            end

            default: state_next = ST_GAP;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        wr_en   = 1'b0;
        wr_data = 6'b000000;
        ready   = 1'b0;
        case (state_reg)
            ST_GAP: begin
                wr_en   = (gap_cnt_reg != 6'd0);
                wr_data = 6'b000000;
            end
            ST_EMIT: begin
                wr_en   = 1'b1;
                wr_data = emit_row;
            end
            ST_DONE: ready = 1'b1;
            default: ;
        endcase
    end

    // The buffer is written only while building, and it is read only when
    // ready. Reads and writes therefore never overlap. Reset does not
    // clear the contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            seg_mem[wr_row_reg] <= wr_data;
        end
    end

    assign data     = ready ? seg_mem[data_addr] : 6'b000000;
    assign underrun = underrun_reg;

endmodule

// File: tb/tb_wall_segment_sequencer.sv
module tb_wall_segment_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] difficulty = 2'd0;
    logic       hold_a = 1'b0;
    logic       hold_b = 1'b0;
    logic [5:0] data_addr = 6'd0;
    logic [5:0] data_a, data_b;
    logic       ready_a, ready_b;
    logic       underrun_a, underrun_b;

    int checks   = 0;
    int failures = 0;

    logic [5:0] exp_rows [64];
    logic [5:0] got_rows [64];
    logic [5:0] exp_q [$];
    logic [15:0] la, lb;

    always #5 clk = ~clk;

    // Default parameters: SEED ACE1, START_GAP 8.
    wall_segment_sequencer dut_a (
        .clk(clk), .reset(reset), .difficulty(difficulty), .hold(hold_a),
        .data_addr(data_addr), .data(data_a), .ready(ready_a), .underrun(underrun_a)
    );

    // The first PICK step from 001E gives 003C, so pat=0 and the raw
    // rotation is 7, which folds to 1.
    wall_segment_sequencer #(.SEED(16'h001E), .START_GAP(0)) dut_b (
        .clk(clk), .reset(reset), .difficulty(difficulty), .hold(hold_b),
        .data_addr(data_addr), .data(data_b), .ready(ready_b), .underrun(underrun_b)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end else begin
            $display("check %s got=%h", tag, got);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int plen(input int p);
        case (p)
            0: return 1;
            1: return 2;
            2: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic logic [5:0] prow(input int p, input int i);
        case (p)
            0: return 6'b111110;
            1: return (i == 0) ? 6'b111100 : 6'b000000;
            2: return (i == 0) ? 6'b100100 : ((i == 1) ? 6'b010010 : 6'b001001);
            default: return 6'b101010;
        endcase
    endfunction

    function automatic logic [5:0] rotl(input logic [5:0] r, input int k);
        logic [11:0] t;
        t = {r, r} << k;
        return t[11:6];
    endfunction

    task automatic model_segment(input logic [15:0] lin, input int gap0, input int diff,
                                 output logic [15:0] lout);
        int row = 0;
        int gap = gap0;
        logic [15:0] l = lin;
        logic fb;
        int pat, rot;
        logic mir;
        logic [5:0] rr, rv;
        while (row < 64) begin
            for (int g = 0; g < gap && row < 64; g++) begin
                exp_rows[row] = 6'b0;
                row++;
            end
            if (row >= 64) break;
            fb  = l[0] ^ l[2] ^ l[3] ^ l[5];
            l   = {l[14:0], fb};
            pat = int'(l[1:0]);
`ifdef WALL_SEQ_MIRROR_EN
            rot = int'(l[8:6]);
            mir = l[5];
`else
            rot = int'(l[4:2]);
            mir = 1'b0;
`endif
            if (rot >= 6) rot -= 6;
            for (int i = 0; i < plen(pat) && row < 64; i++) begin
                rr = prow(pat, i);
                if (mir) begin
                    for (int b = 0; b < 6; b++) rv[b] = rr[5-b];
                    rr = rv;
                end
                exp_rows[row] = rotl(rr, rot);
                row++;
            end
            gap = 6 - diff;
        end
        lout = l;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1; hold_a = 1'b0; hold_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_ready(input bit sel, input int max, input string tag);
        int n = 0;
        @(negedge clk);
        while (((sel ? ready_b : ready_a) !== 1'b1) && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, 16'(sel ? ready_b : ready_a), 16'd1);
    endtask

    // Reads one full segment. Each expected row is queued as its address is
    // driven and is popped when the row is sampled.
    task automatic burst(input bit sel, input string tag);
        logic [5:0] e, g;
        for (int a = 0; a < 64; a++) begin
            @(posedge clk); #1;
            if (sel) hold_b = 1'b1; else hold_a = 1'b1;
            data_addr = 6'(a);
            exp_q.push_back(exp_rows[a]);
            @(negedge clk);
            g = sel ? data_b : data_a;
            got_rows[a] = g;
            e = exp_q.pop_front();
            check($sformatf("%s_row%0d", tag, a), 16'(g), 16'(e));
        end
        @(posedge clk); #1 hold_a = 1'b0; hold_b = 1'b0; data_addr = 6'd0;
        @(negedge clk);
        check({tag, "_ready_drop"}, 16'(sel ? ready_b : ready_a), 16'd0);
    endtask

    initial begin
        // Reset state, then a hold one cycle after reset (underrun).
        difficulty = 2'd0;
        do_reset();
        @(negedge clk);
        check("rst_ready", 16'(ready_a), 16'd0);
        check("rst_underrun", 16'(underrun_a), 16'd0);
        check("rst_data", 16'(data_a), 16'd0);
        @(posedge clk); #1 hold_a = 1'b1; data_addr = 6'd0;
        @(negedge clk);
        check("early_hold_data", 16'(data_a), 16'd0);
        @(posedge clk); #1 hold_a = 1'b0;
        @(negedge clk);
        check("underrun_set", 16'(underrun_a), 16'd1);

        // First segment after reset.
        wait_ready(1'b0, 200, "seg1_ready");
        model_segment(16'hACE1, 8, 0, la);
        burst(1'b0, "seg1");
`ifndef WALL_SEQ_MIRROR_EN
        check("seg1_row8",  16'(got_rows[8]),  16'(6'b100100));
        check("seg1_row9",  16'(got_rows[9]),  16'(6'b010010));
        check("seg1_row10", 16'(got_rows[10]), 16'(6'b001001));
`endif

        // Rebuild after the burst, with the LFSR continuing.
        wait_ready(1'b0, 128, "seg2_ready_within_128");
        model_segment(la, 6, 0, la);
        burst(1'b0, "seg2");
        check("underrun_sticky", 16'(underrun_a), 16'd1);

        // Rotation folding: pat 0 with raw rotation 7.
        model_segment(16'h001E, 0, 0, lb);
        burst(1'b1, "rot7");
`ifndef WALL_SEQ_MIRROR_EN
        check("rot7_row0_const", 16'(got_rows[0]), 16'(6'b111101));
`endif
        check("b_no_underrun", 16'(underrun_b), 16'd0);

        // Difficulty 3: shorter gaps, same pattern order.
        difficulty = 2'd3;
        do_reset();
        @(negedge clk);
        check("underrun_cleared", 16'(underrun_a), 16'd0);
        wait_ready(1'b0, 200, "d3_ready");
        model_segment(16'hACE1, 8, 3, la);
        burst(1'b0, "d3");

        // Reset mid-build, then a clean rebuild.
        difficulty = 2'd0;
        do_reset();
        repeat (35) @(posedge clk);
        @(negedge clk);
        check("midbuild_ready", 16'(ready_a), 16'd0);
        do_reset();
        @(negedge clk);
        check("midbuild_rst_ready", 16'(ready_a), 16'd0);
        wait_ready(1'b0, 200, "rebuild_ready");
        model_segment(16'hACE1, 8, 0, la);
        burst(1'b0, "rebuild");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
